// File: rtl/timer_pkg.sv
// Shared types for the microwave timer input path: BCD digit constants,
// key-detect FSM states and the four-digit MM:SS time register.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    WAIT_KEY     = 2'd0,
    WAIT_RELEASE = 2'd1,
    DEBOUNCE     = 2'd2
  } key_state_t;

  // Field order matches the display, so a left shift is a plain concatenation.
  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/timer_digit_loader_if.sv
// Keypad-encoder side and countdown-load side of the digit loader.
// master = encoder/controller driving keys, slave = the loader itself.
interface timer_digit_loader_if;
  import timer_pkg::*;

  logic [BCD_W-1:0] B;
  logic             dv;
  logic             load_en;
  logic             clear;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [2:0]       digit_count;
  logic             digit_stb;
  logic             full;

  modport master (
    output B, dv, load_en, clear,
    input  min_tens, min_ones, sec_tens, sec_ones, digit_count, digit_stb, full
  );

  modport slave (
    input  B, dv, load_en, clear,
    output min_tens, min_ones, sec_tens, sec_ones, digit_count, digit_stb, full
  );

endinterface

// File: rtl/timer_digit_loader_key_press_detect.sv
// Turns the encoder's level dv into a single press pulse per physical key press.
// Optional DEBOUNCE_EN macro adds a DEBOUNCE state requiring DEBOUNCE_CYCLES high edges.
module key_press_detect
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dv_i,
  output logic press_o
);

  key_state_t state_q;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // The WAIT_KEY edge already counts as the first high sample.
  always_comb begin
    press_o = dv_i && (((state_q == WAIT_KEY) && (DEBOUNCE_CYCLES <= 1)) ||
                       ((state_q == DEBOUNCE) && (cnt_q == CNT_LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_RELEASE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        WAIT_KEY: begin
          cnt_q <= '0;
          if (dv_i) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state_q <= WAIT_RELEASE;
            end else begin
              state_q <= DEBOUNCE;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!dv_i) begin
            state_q <= WAIT_KEY;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q <= '0;
          if (!dv_i) state_q <= WAIT_KEY;
        end
      endcase
    end
  end
`else
  always_comb begin
    press_o = dv_i && (state_q == WAIT_KEY);
  end

  // Reset into WAIT_RELEASE so a key held through reset is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_RELEASE;
    end else begin
      case (state_q)
        WAIT_KEY:  if (dv_i)  state_q <= WAIT_RELEASE;
        default:   if (!dv_i) state_q <= WAIT_KEY;
      endcase
    end
  end
`endif

endmodule

// File: rtl/timer_digit_loader.sv
// Assembles keypad digits into the MM:SS cooking-time register, newest digit in sec_ones.
// Build with DEBOUNCE_EN defined to debounce dv for DEBOUNCE_CYCLES edges before a press counts.
module timer_digit_loader
  import timer_pkg::*;
#(
  parameter int MAX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_digit_loader_if.slave  bus
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  bcd_time_t  time_q, time_d;
  logic [2:0] count_q, count_d;
  logic       full_q, full_d;
  logic       stb_q, stb_d;
  logic       press;
  logic       accept;

  key_press_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_detect (
    .clk    (clk),
    .rst    (rst),
    .dv_i   (bus.dv),
    .press_o(press)
  );

  assign accept = press && bus.load_en && is_bcd(bus.B) &&
                  (count_q < MAX_CNT) && !bus.clear;

  // Clear wins over a simultaneous press; the detector still consumes that press.
  always_comb begin
    time_d  = time_q;
    count_d = count_q;
    full_d  = full_q;
    stb_d   = 1'b0;
    if (bus.clear) begin
      time_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (accept) begin
      time_d  = {time_q.min_ones, time_q.sec_tens, time_q.sec_ones, bus.B};
      count_d = count_q + 3'd1;
      full_d  = ((count_q + 3'd1) == MAX_CNT);
      stb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      count_q <= count_d;
      full_q  <= full_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.min_tens    = time_q.min_tens;
  assign bus.min_ones    = time_q.min_ones;
  assign bus.sec_tens    = time_q.sec_tens;
  assign bus.sec_ones    = time_q.sec_ones;
  assign bus.digit_count = count_q;
  assign bus.digit_stb   = stb_q;
  assign bus.full        = full_q;

endmodule

// File: tb/tb_timer_digit_loader.sv
// Scoreboard bench for timer_digit_loader: each accepted press queues its expected
// digits, count and strobe cycle, which the strobe monitor pops and compares.
module tb_timer_digit_loader;
  import timer_pkg::*;

  localparam int MAXD = 4;
  localparam int DC   = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT  = DC;
  localparam int HOLD = DC + 2;
`else
  localparam int LAT  = 1;
  localparam int HOLD = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_digit_loader_if bus();

  timer_digit_loader #(
    .MAX_DIGITS     (MAXD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic [2:0]  count;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        mon;
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          mCount;
  int          mStrobes = 0;
  int          seenStrobes = 0;
  logic [3:0]  mDig[4];
  logic        mLoadEn;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelDigits();
    return {mDig[0], mDig[1], mDig[2], mDig[3]};
  endfunction

  function automatic logic [15:0] dutDigits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 4; i++) mDig[i] = 4'd0;
    mCount = 0;
  endtask

  task automatic setLoadEn(input logic v);
    @(negedge clk);
    bus.load_en = v;
    mLoadEn     = v;
  endtask

  task automatic applyClear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    modelClear();
  endtask

  // One physical press: dv high for 'hold' edges, optional clear on the detection edge.
  task automatic applyStimulus(input logic [3:0] b, input int hold, input int gap,
                               input bit clrAtPress);
    int start;
    @(negedge clk);
    start = cycleCount;
    if (hold >= LAT) begin
      if (clrAtPress) begin
        modelClear();
      end else if (mLoadEn && (b <= 4'd9) && (mCount < MAXD)) begin
        mDig[0] = mDig[1];
        mDig[1] = mDig[2];
        mDig[2] = mDig[3];
        mDig[3] = b;
        mCount++;
        mStrobes++;
        sbQ.push_back('{start + LAT, modelDigits(), 3'(mCount)});
      end
    end
    bus.B  = b;
    bus.dv = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      bus.clear = clrAtPress && (i == LAT);
      @(negedge clk);
    end
    bus.clear = 1'b0;
    bus.dv    = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_digits"}, dutDigits(), modelDigits());
    checkOutput({tag, "_count"}, bus.digit_count, mCount);
    checkOutput({tag, "_full"}, bus.full, (mCount == MAXD));
    checkOutput({tag, "_stb"}, bus.digit_stb, 0);
    checkOutput({tag, "_strobes"}, seenStrobes, mStrobes);
  endtask

  always @(posedge clk) cycleCount++;

  always @(posedge clk) begin
    #1;
    if (bus.digit_stb === 1'b1) begin
      seenStrobes++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_stb", 1, 0);
      end else begin
        mon = sbQ.pop_front();
        checkOutput("stb_cycle", cycleCount, mon.cyc);
        checkOutput("stb_digits", dutDigits(), mon.digits);
        checkOutput("stb_count", bus.digit_count, mon.count);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelClear();
    bus.B       = 4'd6;
    bus.dv      = 1'b1;
    bus.load_en = 1'b1;
    mLoadEn     = 1'b1;
    bus.clear   = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    checkState("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.dv = 1'b0;
    repeat (2) @(negedge clk);
    checkState("held_through_reset");

    applyStimulus(4'd1, HOLD, 2, 1'b0);
    applyStimulus(4'd2, HOLD, 2, 1'b0);
    applyStimulus(4'd3, HOLD, 2, 1'b0);
    applyStimulus(4'd0, HOLD, 2, 1'b0);
    checkState("fill");
    checkOutput("fill_value", dutDigits(), 16'h1230);

    applyStimulus(4'd7, HOLD, 2, 1'b0);
    checkState("full_reject");
    checkOutput("full_reject_value", dutDigits(), 16'h1230);

    applyClear();
    checkState("clear_idle");

    applyStimulus(4'd5, 20, 2, 1'b0);
    checkState("long_hold");
    checkOutput("long_hold_value", dutDigits(), 16'h0005);

    applyClear();
    setLoadEn(1'b0);
    applyStimulus(4'd8, HOLD, 2, 1'b0);
    checkState("load_en_low");
    setLoadEn(1'b1);
    applyStimulus(4'd11, HOLD, 2, 1'b0);
    checkState("non_bcd");
    applyStimulus(4'd3, HOLD, 2, 1'b0);
    checkState("after_reject");

    applyClear();
    applyStimulus(4'd1, HOLD, 2, 1'b0);
    applyStimulus(4'd2, HOLD, 2, 1'b0);
    checkState("two_digits");
    applyStimulus(4'd4, HOLD, 2, 1'b1);
    checkState("clear_with_press");
    checkOutput("clear_with_press_value", dutDigits(), 16'h0000);
    applyStimulus(4'd4, HOLD, 2, 1'b0);
    checkState("after_clear_press");
    checkOutput("after_clear_press_value", dutDigits(), 16'h0004);

    applyStimulus(4'd7, HOLD, 2, 1'b0);
    applyStimulus(4'd9, HOLD, 2, 1'b0);
    checkState("no_normalise");
    checkOutput("no_normalise_value", dutDigits(), 16'h0479);

`ifdef DEBOUNCE_EN
    applyClear();
    applyStimulus(4'd6, DC - 1, 2, 1'b0);
    checkState("debounce_glitch");
    applyStimulus(4'd9, DC, 2, 1'b0);
    checkState("debounce_press");
    checkOutput("debounce_press_value", dutDigits(), 16'h0009);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    checkOutput("strobe_total", seenStrobes, mStrobes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
